// File: rtl/fpu_pkg.sv
// Shared FP32 constants, rounding-mode encoding and the rounding-increment decision.
package fpu_pkg;

  typedef enum logic [1:0] {
    RNE = 2'd0,
    RTZ = 2'd1,
    RUP = 2'd2
  } rnd_mode_e;

  localparam int unsigned FP32_BIAS   = 127;
  localparam int unsigned FP32_FRAC_W = 23;
  localparam int unsigned FP32_EXP_W  = 8;
  localparam int unsigned FP32_SIG_W  = FP32_FRAC_W + 1;

  // Unlisted code 3 falls into the default arm and so rounds like RNE.
  function automatic logic round_inc(input logic [1:0] mode, input logic lsb,
                                     input logic guard, input logic sticky);
    logic inc;
    case (mode)
      RTZ:     inc = 1'b0;
      RUP:     inc = guard;
      default: inc = guard & (sticky | lsb);
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/itof_lzc.sv
// Combinational leading-zero counter; cnt_o is meaningless when all_zero_o is set.
module itof_lzc #(
  parameter int unsigned Width = 32,
  localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] in_i,
  output logic [CntW-1:0]  cnt_o,
  output logic             all_zero_o
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    cnt_o      = '0;
    all_zero_o = 1'b1;
    for (int i = 0; i < Width; i++) begin
      if (in_i[i]) begin
        cnt_o      = CntW'(Width - 1 - i);
        all_zero_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/itof_pipe.sv
// Three-stage integer to IEEE-754 binary32 converter with valid/ready flow control.
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  adata,
  input  logic             is_unsigned,
  input  logic [1:0]       rnd_mode,
  input  logic             flag_in,
  input  logic [TAG_W-1:0] address_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic             inexact,
  output logic             flag_out,
  output logic [TAG_W-1:0] address_out
);

  localparam int unsigned LzcW = $clog2(IN_W);
  localparam int unsigned ExtW = IN_W + FP32_SIG_W;
  localparam int unsigned SumW = FP32_SIG_W + 1;

  logic s1_adv, s2_adv, s3_adv;
  logic s1_valid_q, s2_valid_q;

  // A stage may load when it is empty or its contents move on this cycle.
  assign s3_adv   = ~out_valid | out_ready;
  assign s2_adv   = ~s2_valid_q | s3_adv;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  // ---------------- Stage 1: sign / magnitude ----------------
  logic            sign_d;
  logic [IN_W-1:0] mag_d;

  // Negation wraps at IN_W bits, so the most negative value maps to 2^(IN_W-1).
  always_comb begin
    sign_d = ~is_unsigned & adata[IN_W-1];
    mag_d  = sign_d ? -adata : adata;
  end

  logic             s1_sign_q;
  logic [IN_W-1:0]  s1_mag_q;
  logic [1:0]       s1_rnd_q;
  logic             s1_flag_q;
  logic [TAG_W-1:0] s1_addr_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_sign_q <= sign_d;
      s1_mag_q  <= mag_d;
      s1_rnd_q  <= rnd_mode;
      s1_flag_q <= flag_in;
      s1_addr_q <= address_in;
    end
  end

  // ---------------- Stage 2: leading-zero count, normalise ----------------
  logic [LzcW-1:0]       lz_cnt;
  logic                  lz_zero;
  logic [IN_W-1:0]       norm_d;
  logic [FP32_EXP_W-1:0] exp_d;

  itof_lzc #(
    .Width (IN_W)
  ) u_lzc (
    .in_i       (s1_mag_q),
    .cnt_o      (lz_cnt),
    .all_zero_o (lz_zero)
  );

  always_comb begin
    norm_d = s1_mag_q << lz_cnt;
    exp_d  = FP32_EXP_W'(FP32_BIAS + IN_W - 1) - FP32_EXP_W'(lz_cnt);
  end

  logic                  s2_sign_q;
  logic                  s2_zero_q;
  logic [IN_W-1:0]       s2_norm_q;
  logic [FP32_EXP_W-1:0] s2_exp_q;
  logic [1:0]            s2_rnd_q;
  logic                  s2_flag_q;
  logic [TAG_W-1:0]      s2_addr_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s2_valid_q <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (s2_adv && s1_valid_q) begin
      s2_sign_q <= s1_sign_q;
      s2_zero_q <= lz_zero;
      s2_norm_q <= norm_d;
      s2_exp_q  <= exp_d;
      s2_rnd_q  <= s1_rnd_q;
      s2_flag_q <= s1_flag_q;
      s2_addr_q <= s1_addr_q;
    end
  end

  // ---------------- Stage 3: round, renormalise, pack ----------------
  logic [ExtW-1:0]        ext;
  logic [FP32_SIG_W-1:0]  sig;
  logic                   guard, sticky, inc, carry;
  logic [SumW-1:0]        rnd_sig;
  logic [FP32_FRAC_W-1:0] frac;
  logic [FP32_EXP_W-1:0]  exp_fin;
  logic [31:0]            result_d;
  logic                   inexact_d;

  // Right zero-padding lets narrow operands share the same guard/sticky slicing.
  always_comb begin
    ext       = {s2_norm_q, {FP32_SIG_W{1'b0}}};
    sig       = ext[ExtW-1 -: FP32_SIG_W];
    guard     = ext[ExtW-1-FP32_SIG_W];
    sticky    = |ext[ExtW-2-FP32_SIG_W:0];
    inc       = round_inc(s2_rnd_q, sig[0], guard, sticky);
    rnd_sig   = {1'b0, sig} + SumW'(inc);
    carry     = rnd_sig[FP32_SIG_W];
    frac      = carry ? '0 : rnd_sig[FP32_FRAC_W-1:0];
    exp_fin   = s2_exp_q + FP32_EXP_W'(carry);
    result_d  = s2_zero_q ? 32'h0 : {s2_sign_q, exp_fin, frac};
    inexact_d = guard | sticky;
  end

  logic unused_hidden;
  assign unused_hidden = rnd_sig[FP32_FRAC_W];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid   <= 1'b0;
      result      <= '0;
      inexact     <= 1'b0;
      flag_out    <= 1'b0;
      address_out <= '0;
    end else if (s3_adv) begin
      out_valid <= s2_valid_q;
      if (s2_valid_q) begin
        result      <= result_d;
        inexact     <= inexact_d;
        flag_out    <= s2_flag_q;
        address_out <= s2_addr_q;
      end
    end
  end

endmodule
